// File: rtl/rr_res_arbiter_pkg.sv
// Shared definitions for the round-robin resource arbiter: state encoding,
// select widths and the park value for the shared datapath mux.
package rr_res_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    localparam logic [SEL_W-1:0] PARK_SEL = 3'b100;

    // Single 2-to-3 zero-extender shared by every place that widens an ID into a select.
    function automatic logic [SEL_W-1:0] zext_id(input logic [ID_W-1:0] id);
        return {1'b0, id};
    endfunction

endpackage

// File: rtl/rr_res_arbiter_pick4.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, then add ptr back to recover the absolute requester index.
module rr_pick4
    import rr_res_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] win_o,
    output logic            any_o
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [ID_W-1:0]   offset;

    assign req_dbl = {req_i, req_i};
    // req_rot[0] corresponds to requester ptr, req_rot[1] to ptr+1, and so on.
    assign req_rot = req_dbl[ptr_i +: NREQ];

    always_comb begin
        offset = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = ID_W'(i);
            end
        end
    end

    assign win_o = ptr_i + offset;
    assign any_o = |req_i;

endmodule

// File: rtl/rr_res_arbiter.sv
// Round-robin owner of the shared 3-bit-select datapath: grants one of four
// requesters, limits hold time and inserts a turnaround cycle between owners.
//
// state | meaning
// IDLE  | resource parked, arbitrating over req each cycle
// OWN   | one requester owns the resource, hold counter running
// TURN  | mandatory bus-turnaround cycle, req ignored
module rr_res_arbiter
    import rr_res_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic [SEL_W-1:0] mux_sel_o,
    output logic             busy_o,
    output logic             preempt_o
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_e           state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [NREQ-1:0]  gnt_q;
    logic [ID_W-1:0]  gnt_id_q;
    logic             busy_q;
    logic             preempt_q;

    logic [ID_W-1:0]  win;
    logic             any_req;

    rr_pick4 u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (win),
        .any_o (any_req)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= OWN;
                        gnt_q      <= NREQ'(1) << win;
                        gnt_id_q   <= win;
                        busy_q     <= 1'b1;
                        hold_cnt_q <= CNT_W'(1);
                    end
                end
                OWN: begin
                    // A voluntary drop wins over a timeout on the same cycle, so no preempt then.
                    if (!req_i[gnt_id_q] || hold_cnt_q == HOLD_LIMIT) begin
                        state_q   <= TURN;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= gnt_id_q + 1'b1;
                        preempt_q <= req_i[gnt_id_q];
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign busy_o    = busy_q;
    assign preempt_o = preempt_q;
    assign mux_sel_o = (state_q == OWN) ? zext_id(gnt_id_q) : PARK_SEL;

endmodule

// File: tb/tb_rr_res_arbiter.sv
// Self-checking bench for rr_res_arbiter: directed scenarios plus random
// request patterns, compared every cycle against a behavioural owner model.
module tb_rr_res_arbiter;

    localparam int MAXH = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic [2:0] mux_sel;
    logic       busy;
    logic       preempt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: who owns the resource, how long, where the scan starts.
    int m_owner;
    int m_hold;
    int m_ptr;
    bit m_turn;
    bit m_pre;

    rr_res_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .mux_sel_o (mux_sel),
        .busy_o    (busy),
        .preempt_o (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_turn  = 1'b0;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        m_pre = 1'b0;
        if (m_turn) begin
            m_turn = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_hold  = 1;
                end
            end
        end else begin
            if (!r[m_owner] || m_hold == MAXH) begin
                m_pre   = r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_turn  = 1'b1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e_gnt;
        logic [2:0] e_sel;
        e_gnt = 4'b0000;
        e_sel = 3'b100;
        if (m_owner >= 0) begin
            e_gnt = 4'(1 << m_owner);
            e_sel = 3'(m_owner);
        end
        cmp("gnt", 8'(gnt), 8'(e_gnt));
        cmp("busy", 8'(busy), 8'(m_owner >= 0));
        cmp("mux_sel", 8'(mux_sel), 8'(e_sel));
        cmp("preempt", 8'(preempt), 8'(m_pre));
        cmp("sel2_while_busy", 8'(mux_sel[2] & busy), 8'd0);
        if (m_owner >= 0) begin
            cmp("gnt_id", 8'(gnt_id), 8'(m_owner));
        end
    endtask

    // Called at posedge+1: drive req, take one edge, update model, check.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_gnt", 8'(gnt), 8'h0);
        cmp("rst_gnt_id", 8'(gnt_id), 8'h0);
        cmp("rst_mux_sel", 8'(mux_sel), 8'h4);
        cmp("rst_busy", 8'(busy), 8'h0);
        cmp("rst_preempt", 8'(preempt), 8'h0);
        rst_n = 1'b1;

        // Idle system stays parked.
        repeat (20) cyc(4'b0000);

        // Single requester 2, voluntary release after 3 cycles.
        cyc(4'b0100);
        cmp("dir_gnt2", 8'(gnt), 8'h04);
        cmp("dir_sel2", 8'(mux_sel), 8'h02);
        cyc(4'b0100);
        cyc(4'b0100);
        cyc(4'b0000);
        cmp("dir_turn_gnt", 8'(gnt), 8'h00);
        cyc(4'b0000);
        // ptr now 3: with 1 and 3 both requesting, 3 wins.
        cyc(4'b1010);
        cmp("dir_ptr3", 8'(gnt), 8'h08);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);

        // All requesting: rotating grants with timeouts (ptr wraps 3 -> 0).
        repeat (55) cyc(4'b1111);
        repeat (3) cyc(4'b0000);

        // Lone requester 1 gets regranted after each timeout.
        repeat (30) cyc(4'b0010);
        repeat (3) cyc(4'b0000);

        // Owner 3 drops req on the cycle its hold count reaches MAX_HOLD.
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        cyc(4'b1000);
        cmp("own3_gnt", 8'(gnt), 8'h08);
        repeat (MAXH - 1) cyc(4'b1000);
        cyc(4'b0000);
        cmp("simul_drop_preempt", 8'(preempt), 8'h0);
        cmp("simul_drop_busy", 8'(busy), 8'h0);
        cyc(4'b1111);  // TURN: ignored
        cmp("turn_ignores_req", 8'(gnt), 8'h00);
        cyc(4'b1111);
        cmp("after_wrap_gnt0", 8'(gnt), 8'h01);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0000);

        // Async reset mid-ownership of requester 1.
        cyc(4'b0010);
        cyc(4'b0010);
        cmp("pre_rst_gnt", 8'(gnt), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp("async_gnt", 8'(gnt), 8'h00);
        cmp("async_busy", 8'(busy), 8'h00);
        cmp("async_sel", 8'(mux_sel), 8'h04);
        cmp("async_preempt", 8'(preempt), 8'h00);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cyc(4'b0011);
        cmp("post_rst_gnt0", 8'(gnt), 8'h01);

        // Random request patterns, each held for a random number of cycles.
        for (int seg = 0; seg < 60; seg++) begin
            logic [3:0] r;
            int len;
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                cyc(r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_res_arbiter.md
Name: rr_res_arbiter

Overview:
- Round-robin arbiter granting one shared 3-bit-select datapath resource to up to four requesters.
- The winning 2-bit requester ID is zero-extended to the 3-bit datapath select; select 3'b100 parks the resource on its default (idle) source.
- Sits between the requester blocks and the shared mux/datapath; owns all sequencing of that resource.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 because the ID is 2 bits.
- MAX_HOLD, 8, maximum consecutive owned cycles before forced release. Legal range 1..15.
- CNT_W, 4, hold-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-requester request, level, held high while the resource is wanted.
- gnt  out  4  one-hot grant, registered.
- gnt_id  out  2  binary index of the current owner; valid when busy=1.
- mux_sel  out  3  datapath select: {1'b0, gnt_id} when owned, 3'b100 when parked.
- busy  out  1  resource currently owned.
- preempt  out  1  one-cycle pulse on the cycle a grant is revoked by timeout.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchroniser):
  - gnt=0, gnt_id=0, mux_sel=3'b100, busy=0, preempt=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- States: IDLE, OWN, TURN.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: state=OWN, gnt=onehot(win), gnt_id=win, busy=1, hold_cnt=1.
  - Grant latency is exactly 1 cycle from req sampled high in IDLE.
- OWN:
  - Requester drops req[gnt_id]: next edge goes to TURN. gnt=0, busy=0, ptr=gnt_id+1 mod 4, no preempt.
  - Else if hold_cnt==MAX_HOLD: next edge goes to TURN. gnt=0, busy=0, ptr=gnt_id+1 mod 4, preempt=1 for that one cycle.
  - Else hold_cnt increments and the grant is held. Changes on other req bits are ignored.
  - The owner holds the grant for at most MAX_HOLD cycles.
- TURN:
  - One mandatory bus-turnaround cycle; mux_sel=3'b100.
  - Next edge always returns to IDLE.
  - Back-to-back grants are therefore separated by at least 2 idle cycles (TURN + IDLE arbitration).
- mux_sel:
  - Combinational from registered state: {1'b0, gnt_id} in OWN, 3'b100 otherwise.
  - Bit 2 is never 1 while busy=1.
- Boundary conditions:
  - Preempted owner still requesting with no other request pending: regranted after TURN+IDLE. The pointer rotates past it, but the scan wraps back to it.
  - Simultaneous drop of req[owner] and hold_cnt==MAX_HOLD: treated as a voluntary release, preempt=0.
  - ptr wraps 3 to 0.
  - req changing during TURN is ignored; it is sampled only in IDLE.
  - rst_n asserted mid-ownership: gnt, busy and mux_sel return to reset values immediately (async), with no preempt pulse.
  - req bits for a fully idle system: the arbiter stays in IDLE with outputs parked indefinitely.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, OWN=2'd1, TURN=2'd2;
  - PARK_SEL=3'b100;
  - ID_W=2 and SEL_W=3.
- One natural sub-module: rr_pick4.
  - Purely combinational.
  - Inputs req[3:0] and ptr[1:0]; outputs win[1:0] and any.
  - Implemented as a rotate, priority-encode, add-back scheme.
- The {1'b0, id} select widening reuses the existing 2-to-3 zero-extender instance.

Test Plan:
- Reset then req=4'b0000 for 20 cycles -> gnt=0, busy=0, mux_sel=3'b100 throughout.
- req=4'b0100 at cycle t in IDLE -> at t+1 gnt=4'b0100, gnt_id=2, mux_sel=3'b010. Drop req at t+3 -> gnt=0 at t+4 (TURN), ptr=3.
- req=4'b1111 held continuously, MAX_HOLD=8 -> grants cycle 0,1,2,3,0. Each lasts 8 cycles, each end has preempt=1 for one cycle, and there is a 2-cycle gap between grants.
- Only req[1] held for 30 cycles -> owns 8 cycles, preempt pulse, TURN, IDLE, regranted to ID 1. The pattern repeats, and mux_sel alternates between 3'b001 and 3'b100.
- Owner ID 3 drops req on the same cycle hold_cnt reaches 8 -> TURN entered, preempt stays 0, next grant search starts at ptr=0.
- rst_n pulled low mid-OWN with gnt=4'b0010 -> gnt=0, busy=0 and mux_sel=3'b100 asynchronously, before the next clk edge. After release, req=4'b0011 yields a grant to ID 0 (ptr reset to 0).
